// File: rtl/intf_reduce.sv
// intf_reduce
// -----------------------------------------------------------------------------
// Per-channel input FIFOs feeding a bitwise reduction stage that writes into an
// output FIFO. A combine pops one head from every input FIFO and pushes the
// reduced word into the output FIFO. It needs every input FIFO non-empty and
// the output FIFO not full.
//
// Parameters
//   WIDTH  data bits per channel and result width
//   NCH    number of input channels (2..8)
//   DEPTH  entries per FIFO, power of two, >= 2
//
// Ports
//   CLK      clock, all state updates on the rising edge
//   RST_N    asynchronous active-low reset
//   in_data  NCH*WIDTH  channel i data in [i*WIDTH +: WIDTH]
//   in_en    NCH        per-channel enqueue strobe
//   in_rdy   NCH        per-channel ready (input FIFO not full)
//   mode     2          00 OR, 01 AND, 10 XOR, 11 NOR
//   y_en     1          result dequeue strobe
//   y_data   WIDTH      output FIFO head, forced to 0 while y_rdy=0
//   y_rdy    1          output FIFO not empty
//   err      1          sticky protocol error (enable while not ready)
//   cnt      16         completed combines, wrapping
// -----------------------------------------------------------------------------
module intf_reduce #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_en,
    output logic [NCH-1:0]       in_rdy,
    input  logic [1:0]           mode,
    input  logic                 y_en,
    output logic [WIDTH-1:0]     y_data,
    output logic                 y_rdy,
    output logic                 err,
    output logic [15:0]          cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [AW:0] ptr_t;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    logic [WIDTH-1:0] in_mem  [NCH][DEPTH];
    ptr_t             in_wp   [NCH];
    ptr_t             in_rp   [NCH];
    logic [WIDTH-1:0] head    [NCH];
    logic [NCH-1:0]   in_empty;
    logic [NCH-1:0]   in_full;
    logic [NCH-1:0]   enq;

    logic [WIDTH-1:0] out_mem [DEPTH];
    ptr_t             out_wp;
    ptr_t             out_rp;
    logic             out_empty;
    logic             out_full;

    logic             combine;
    logic             deq;
    logic             violation;
    op_e              op;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] result;

    // ---------------------------------------------------------------------
    // FIFO status, derived from registered pointers only
    // ---------------------------------------------------------------------
    always_comb begin
        in_empty = '0;
        in_full  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            in_empty[i] = (in_wp[i] == in_rp[i]);
            in_full[i]  = (in_wp[i][AW] != in_rp[i][AW]) &&
                          (in_wp[i][AW-1:0] == in_rp[i][AW-1:0]);
            head[i]     = in_mem[i][in_rp[i][AW-1:0]];
        end
    end

    assign out_empty = (out_wp == out_rp);
    assign out_full  = (out_wp[AW] != out_rp[AW]) &&
                       (out_wp[AW-1:0] == out_rp[AW-1:0]);

    assign in_rdy = ~in_full;
    assign y_rdy  = ~out_empty;
    assign y_data = out_empty ? '0 : out_mem[out_rp[AW-1:0]];

    // ---------------------------------------------------------------------
    // Transfer decisions
    // ---------------------------------------------------------------------
    // Readiness comes from pre-edge state, so a full input FIFO refuses data
    // even when a combine frees a slot at the same edge.
    assign enq       = in_en & in_rdy;
    assign deq       = y_en & y_rdy;
    assign combine   = (&(~in_empty)) & ~out_full;
    assign violation = (|(in_en & ~in_rdy)) | (y_en & ~y_rdy);

    // ---------------------------------------------------------------------
    // Reduction of the current heads
    // ---------------------------------------------------------------------
    assign op = op_e'(mode);

    always_comb begin
        red_or  = '0;
        red_and = '1;
        red_xor = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            red_or  = red_or  | head[i];
            red_and = red_and & head[i];
            red_xor = red_xor ^ head[i];
        end
    end

    always_comb begin
        result = red_or;
        case (op)
            OP_OR:   result = red_or;
            OP_AND:  result = red_and;
            OP_XOR:  result = red_xor;
            OP_NOR:  result = ~red_or;
            default: result = red_or;
        endcase
    end

    // ---------------------------------------------------------------------
    // Pointers, counters and error flag
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                in_wp[i] <= '0;
                in_rp[i] <= '0;
            end
            out_wp <= '0;
            out_rp <= '0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (enq[i]) begin
                    in_wp[i] <= in_wp[i] + 1'b1;
                end
                if (combine) begin
                    in_rp[i] <= in_rp[i] + 1'b1;
                end
            end
            if (combine) begin
                out_wp <= out_wp + 1'b1;
                cnt    <= cnt + 16'd1;
            end
            if (deq) begin
                out_rp <= out_rp + 1'b1;
            end
            if (violation) begin
                err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage arrays; contents are don't-care until the pointers cover them
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (enq[i]) begin
                in_mem[i][in_wp[i][AW-1:0]] <= in_data[i*WIDTH +: WIDTH];
            end
        end
        if (combine) begin
            out_mem[out_wp[AW-1:0]] <= result;
        end
    end

endmodule

// File: tb/tb_intf_reduce.sv
// Testbench for intf_reduce with WIDTH=4, NCH=3, DEPTH=2.
// The reference model keeps each FIFO as a queue and applies the transfer
// rules for one clock edge at a time, deciding from the pre-edge occupancy.
module tb_intf_reduce;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int D  = 2;

    logic            CLK;
    logic            RST_N;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_en;
    logic [N-1:0]    in_rdy;
    logic [1:0]      mode;
    logic            y_en;
    logic [W-1:0]    y_data;
    logic            y_rdy;
    logic            err;
    logic [15:0]     cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [W-1:0] mq [N][$];
    logic [W-1:0] moq[$];
    int           mcnt;
    bit           merr;

    intf_reduce #(.WIDTH(W), .NCH(N), .DEPTH(D)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .in_data (in_data),
        .in_en   (in_en),
        .in_rdy  (in_rdy),
        .mode    (mode),
        .y_en    (y_en),
        .y_data  (y_data),
        .y_rdy   (y_rdy),
        .err     (err),
        .cnt     (cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] ref_op(input logic [1:0] m,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        case (m)
            2'b00:   return a | b | c;
            2'b01:   return a & b & c;
            2'b10:   return a ^ b ^ c;
            default: return ~(a | b | c);
        endcase
    endfunction

    function automatic logic [N-1:0] exp_in_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        moq.delete();
        mcnt = 0;
        merr = 0;
    endtask

    // Advance the model by one edge using the currently driven inputs,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        bit comb;
        bit deq;
        logic [W-1:0] h [N];
        comb = (moq.size() < D);
        for (int i = 0; i < N; i++) if (mq[i].size() == 0) comb = 0;
        deq = y_en && (moq.size() > 0);
        if (y_en && moq.size() == 0) merr = 1;
        for (int i = 0; i < N; i++)
            if (in_en[i] && mq[i].size() >= D) merr = 1;
        if (deq) void'(moq.pop_front());
        if (comb) begin
            for (int i = 0; i < N; i++) h[i] = mq[i].pop_front();
            moq.push_back(ref_op(mode, h[0], h[1], h[2]));
            mcnt++;
        end
        // Enqueue decisions use pre-edge fullness: count items left after the
        // combine pop plus the one popped.
        for (int i = 0; i < N; i++)
            if (in_en[i] && (mq[i].size() + (comb ? 1 : 0)) < D)
                mq[i].push_back(in_data[i*W +: W]);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_en   = '0;
        y_en    = 1'b0;
        in_data = '0;
    endtask

    // Asynchronous reset applied away from the clock edge; releases on the
    // next falling edge so the following rising edge runs with RST_N high.
    task automatic pulse_reset();
        #2;
        RST_N = 1'b0;
        model_clear();
        #1;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        idle_inputs();
        mode = 2'b00;
        model_clear();
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 3'b111 || y_rdy !== 1'b0 || y_data !== 4'h0 ||
            err !== 1'b0 || cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset: in_rdy=%b y_rdy=%b y_data=%h err=%b cnt=%h expected 111 0 0 0 0",
                     in_rdy, y_rdy, y_data, err, cnt);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        mode    = 2'b00;
        in_en   = 3'b111;
        in_data = {4'h4, 4'h2, 4'h1};
        tick();
        idle_inputs();
        checks++;
        if (y_rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early: y_rdy=%b expected 0", y_rdy);
        end
        tick();
        checks++;
        if (y_rdy !== 1'b1 || y_data !== 4'h7 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_or: y_rdy=%b y_data=%h cnt=%0d expected 1 7 1", y_rdy, y_data, cnt);
        end
        y_en = 1'b1;
        tick();
        y_en = 1'b0;
        checks++;
        if (y_rdy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_dequeue: y_rdy=%b err=%b expected 0 0", y_rdy, err);
        end
    endtask

    task automatic test_modes();
        logic [1:0]   mlist [3];
        logic [W-1:0] want  [3];
        mlist[0] = 2'b01; want[0] = 4'h1;
        mlist[1] = 2'b10; want[1] = 4'h9;
        mlist[2] = 2'b11; want[2] = 4'h0;
        for (int k = 0; k < 3; k++) begin
            mode    = 2'b00;
            in_en   = 3'b111;
            in_data = {4'h5, 4'h3, 4'hF};
            tick();
            idle_inputs();
            mode = mlist[k];
            tick();
            checks++;
            if (y_rdy !== 1'b1 || y_data !== want[k] || y_data !== moq[0]) begin
                errors++;
                $display("FAIL mode_%b: y_rdy=%b y_data=%h expected 1 %h", mlist[k], y_rdy, y_data, want[k]);
            end
            y_en = 1'b1;
            tick();
            y_en = 1'b0;
        end
        checks++;
        if (cnt !== 16'(mcnt) || cnt !== 16'd4) begin
            errors++;
            $display("FAIL mode_cnt: cnt=%0d expected 4", cnt);
        end
    endtask

    task automatic test_overflow();
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            in_en   = 3'b001;
            in_data = {8'h00, 4'(k + 1)};
            tick();
            if (k == 1) begin
                checks++;
                if (in_rdy !== 3'b110 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_full: in_rdy=%b err=%b expected 110 0", in_rdy, err);
                end
            end
        end
        idle_inputs();
        checks++;
        if (in_rdy !== 3'b110 || err !== 1'b1 || y_rdy !== 1'b0 ||
            mq[0].size() != 2 || !merr) begin
            errors++;
            $display("FAIL overflow_reject: in_rdy=%b err=%b y_rdy=%b expected 110 1 0", in_rdy, err, y_rdy);
        end
        pulse_reset();
    endtask

    task automatic test_backpressure();
        int drained;
        logic [W-1:0] exp_seq[$];
        y_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_en   = exp_in_rdy();
            in_data = N*W'($urandom);
            mode    = 2'($urandom);
            tick();
        end
        idle_inputs();
        checks++;
        if (in_rdy !== 3'b000 || y_rdy !== 1'b1 || cnt !== 16'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_fill: in_rdy=%b y_rdy=%b cnt=%0d err=%b expected 000 1 2 0",
                     in_rdy, y_rdy, cnt, err);
        end
        drained = 0;
        y_en = 1'b1;
        for (int k = 0; k < 10 && moq.size() > 0; k++) begin
            checks++;
            if (y_rdy !== 1'b1 || y_data !== moq[0]) begin
                errors++;
                $display("FAIL backpressure_drain%0d: y_rdy=%b y_data=%h expected 1 %h", k, y_rdy, y_data, moq[0]);
            end
            exp_seq.push_back(moq[0]);
            drained++;
            mode = 2'($urandom);
            tick();
        end
        y_en = 1'b0;
        checks++;
        if (drained != 4 || y_rdy !== 1'b0 || in_rdy !== 3'b111 || cnt !== 16'd4) begin
            errors++;
            $display("FAIL backpressure_total: drained=%0d y_rdy=%b in_rdy=%b cnt=%0d expected 4 0 111 4",
                     drained, y_rdy, in_rdy, cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            in_en   = N'($urandom_range(0, 7));
            in_data = N*W'($urandom);
            mode    = 2'($urandom);
            y_en    = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (in_rdy !== exp_in_rdy() || y_rdy !== (moq.size() > 0) ||
                (moq.size() > 0 && y_data !== moq[0]) ||
                err !== merr || cnt !== 16'(mcnt)) begin
                errors++;
                $display("FAIL random_cycle%0d: in_rdy=%b y_rdy=%b y_data=%h err=%b cnt=%0d expected %b %b %h %b %0d",
                         k, in_rdy, y_rdy, y_data, err, cnt, exp_in_rdy(), moq.size() > 0,
                         (moq.size() > 0) ? moq[0] : 4'h0, merr, 16'(mcnt));
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        y_en = 1'b1;
        tick();
        y_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_en   = 3'b111;
            in_data = N*W'($urandom);
            tick();
        end
        in_en   = 3'b000;
        in_data = '0;
        checks++;
        if (y_rdy !== 1'b1 || err !== 1'b1 || cnt !== 16'd2 || moq.size() != 2) begin
            errors++;
            $display("FAIL resetmid_setup: y_rdy=%b err=%b cnt=%0d expected 1 1 2", y_rdy, err, cnt);
        end
        #2;
        RST_N = 1'b0;
        model_clear();
        #1;
        checks++;
        if (y_rdy !== 1'b0 || cnt !== 16'd0 || err !== 1'b0 ||
            in_rdy !== 3'b111 || y_data !== 4'h0) begin
            errors++;
            $display("FAIL resetmid_async: y_rdy=%b cnt=%0d err=%b in_rdy=%b y_data=%h expected 0 0 0 111 0",
                     y_rdy, cnt, err, in_rdy, y_data);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        // First edge after release must accept data.
        in_en   = 3'b111;
        in_data = {4'h8, 4'h8, 4'h8};
        mode    = 2'b01;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (y_rdy !== 1'b1 || y_data !== 4'h8 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL resetmid_first_enq: y_rdy=%b y_data=%h cnt=%0d expected 1 8 1", y_rdy, y_data, cnt);
        end
        pulse_reset();
    endtask

    task automatic test_stream();
        mode    = 2'b10;
        in_en   = 3'b111;
        in_data = N*W'($urandom);
        tick();
        in_data = N*W'($urandom);
        tick();
        y_en = 1'b1;
        for (int k = 0; k < 69999; k++) begin
            in_data = N*W'($urandom);
            mode    = 2'($urandom);
            tick();
            checks++;
            if (y_rdy !== 1'b1 || moq.size() != 1 || y_data !== moq[0] || in_rdy !== 3'b111) begin
                errors++;
                $display("FAIL stream_cycle%0d: y_rdy=%b y_data=%h in_rdy=%b expected 1 %h 111",
                         k, y_rdy, y_data, in_rdy, moq[0]);
            end
        end
        idle_inputs();
        checks++;
        if (cnt !== 16'd4464 || cnt !== 16'(mcnt) || err !== 1'b0) begin
            errors++;
            $display("FAIL stream_wrap: cnt=%0d err=%b expected 4464 0", cnt, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
